// File: rtl/needs_engine.sv
// Virtual-pet needs engine: six 4-bit needs decaying on a prescaled tick, driven by user care actions.
// Optional NEEDS_SICKNESS_EN: extra health decay on every tick while registered hygiene >= 12.
module needs_engine #(
    parameter logic [23:0] TICK_DIV    = 24'd12_000_000,
    parameter logic [3:0]  ACTION_STEP = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       action_valid,
    input  logic [2:0] action_code,
    output logic       action_ready,
    output logic [3:0] hunger,
    output logic [3:0] happiness,
    output logic [3:0] health,
    output logic [3:0] hygiene,
    output logic [3:0] energy,
    output logic [3:0] social,
    output logic       sleeping,
    output logic       dead
);
    typedef enum logic [1:0] {ST_ALIVE, ST_SLEEPING, ST_DEAD} state_t;

    localparam logic [2:0] A_FEED  = 3'd0;
    localparam logic [2:0] A_PLAY  = 3'd1;
    localparam logic [2:0] A_HEAL  = 3'd2;
    localparam logic [2:0] A_CLEAN = 3'd3;
    localparam logic [2:0] A_SLEEP = 3'd4;
    localparam logic [2:0] A_WAKE  = 3'd5;
    localparam logic [2:0] A_TALK  = 3'd6;

    state_t      r_state, w_next;
    logic [23:0] r_presc;
    logic [1:0]  r_tcnt;
    logic [3:0]  r_hunger, r_happy, r_health, r_hygiene, r_energy, r_social;
    logic        w_any15, w_run, w_tick, w_accept, w_act_alive;
    logic [3:0]  w_inc_hun, w_inc_hap, w_inc_hea, w_inc_hyg, w_inc_ene, w_inc_soc;
    logic [3:0]  w_dec_hun, w_dec_hap, w_dec_hea, w_dec_hyg, w_dec_ene, w_dec_soc;

    // Tick and action contributions are summed in one signed step so they cannot wrap.
    function automatic logic [3:0] f_sat(input logic [3:0] old, input logic [3:0] inc,
                                         input logic [3:0] dec);
        logic signed [5:0] v;
        v = $signed({2'b00, old}) + $signed({2'b00, inc}) - $signed({2'b00, dec});
        if (v < 6'sd0)       f_sat = 4'd0;
        else if (v > 6'sd15) f_sat = 4'd15;
        else                 f_sat = v[3:0];
    endfunction

    assign w_any15 = (r_hunger == 4'd15) || (r_happy == 4'd15) || (r_health == 4'd15) ||
                     (r_hygiene == 4'd15) || (r_energy == 4'd15) || (r_social == 4'd15);
    // A fatal need freezes everything in the cycle before DEAD is entered.
    assign w_run       = (r_state != ST_DEAD) && !w_any15;
    assign w_tick      = w_run && (r_presc == TICK_DIV - 24'd1);
    assign w_accept    = action_valid && action_ready;
    assign w_act_alive = w_accept && w_run && (r_state == ST_ALIVE);

    always_comb begin
        w_inc_hun = 4'd0; w_inc_hap = 4'd0; w_inc_hea = 4'd0;
        w_inc_hyg = 4'd0; w_inc_ene = 4'd0; w_inc_soc = 4'd0;
        w_dec_hun = 4'd0; w_dec_hap = 4'd0; w_dec_hea = 4'd0;
        w_dec_hyg = 4'd0; w_dec_ene = 4'd0; w_dec_soc = 4'd0;
        if (w_tick) begin
            w_inc_hun = 4'd1;
            if (r_tcnt[0]) begin
                w_inc_hap = 4'd1;
                w_inc_hyg = 4'd1;
                w_inc_soc = 4'd1;
            end
            if (r_tcnt == 2'd3) w_inc_hea = 4'd1;
`ifdef NEEDS_SICKNESS_EN
            if (r_hygiene >= 4'd12) w_inc_hea = w_inc_hea + 4'd1;
`endif
            if (r_state == ST_SLEEPING) w_dec_ene = 4'd1;
            else                        w_inc_ene = 4'd1;
        end
        if (w_act_alive) begin
            case (action_code)
                A_FEED:  w_dec_hun = ACTION_STEP;
                A_HEAL:  w_dec_hea = ACTION_STEP;
                A_CLEAN: w_dec_hyg = ACTION_STEP;
                A_TALK:  w_dec_soc = ACTION_STEP;
                A_PLAY: begin
                    w_dec_hap = ACTION_STEP;
                    w_inc_ene = w_inc_ene + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_tcnt    <= '0;
            r_hunger  <= '0;
            r_happy   <= '0;
            r_health  <= '0;
            r_hygiene <= '0;
            r_energy  <= '0;
            r_social  <= '0;
        end else if (w_run) begin
            r_presc   <= w_tick ? 24'd0 : r_presc + 24'd1;
            r_tcnt    <= r_tcnt + {1'b0, w_tick};
            r_hunger  <= f_sat(r_hunger,  w_inc_hun, w_dec_hun);
            r_happy   <= f_sat(r_happy,   w_inc_hap, w_dec_hap);
            r_health  <= f_sat(r_health,  w_inc_hea, w_dec_hea);
            r_hygiene <= f_sat(r_hygiene, w_inc_hyg, w_dec_hyg);
            r_energy  <= f_sat(r_energy,  w_inc_ene, w_dec_ene);
            r_social  <= f_sat(r_social,  w_inc_soc, w_dec_soc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_ALIVE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ALIVE: begin
                if (w_any15) w_next = ST_DEAD;
                else if (w_accept && action_code == A_SLEEP) w_next = ST_SLEEPING;
            end
            ST_SLEEPING: begin
                if (w_any15) w_next = ST_DEAD;
                else if ((w_accept && action_code == A_WAKE) || r_energy == 4'd0) w_next = ST_ALIVE;
            end
            default: w_next = ST_DEAD;
        endcase
    end

    always_comb begin
        action_ready = (r_state != ST_DEAD);
        sleeping     = (r_state == ST_SLEEPING);
        dead         = (r_state == ST_DEAD);
    end

    assign hunger    = r_hunger;
    assign happiness = r_happy;
    assign health    = r_health;
    assign hygiene   = r_hygiene;
    assign energy    = r_energy;
    assign social    = r_social;
endmodule

// File: tb/tb_needs_engine.sv
// Bench for needs_engine: random and directed care sequences checked every cycle against a behavioural model.
module tb_needs_engine;
    localparam int TD   = 4;
    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       action_valid = 1'b0;
    logic [2:0] action_code  = 3'd7;
    logic       action_ready, sleeping, dead;
    logic [3:0] hunger, happiness, health, hygiene, energy, social;

    needs_engine #(.TICK_DIV(24'd4), .ACTION_STEP(4'd4)) dut (
        .clk(clk), .rst(rst), .action_valid(action_valid), .action_code(action_code),
        .action_ready(action_ready), .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social), .sleeping(sleeping), .dead(dead)
    );

    always #5 clk = ~clk;

    // model: needs[0..5] = hunger, happiness, health, hygiene, energy, social; st 0 alive, 1 asleep, 2 dead
    int m_need[6];
    int m_st, m_live, m_ticks;
    bit chk_en = 1'b0;
    int c_chk = 0, c_pass = 0, l_chk = 0, l_pass = 0;

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 15) ? 15 : v);
    endfunction

    function automatic logic [26:0] exp_vec();
        logic [26:0] e;
        e = {m_need[0][3:0], m_need[1][3:0], m_need[2][3:0], m_need[3][3:0],
             m_need[4][3:0], m_need[5][3:0], (m_st == 1), (m_st == 2), (m_st != 2)};
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_need[i] = 0;
        m_st = 0; m_live = 0; m_ticks = 0;
    endtask

    task automatic model_step(input bit v, input int code);
        int nd[6];
        int ns;
        bit tick;
        if (m_st == 2) return;
        for (int i = 0; i < 6; i++) if (m_need[i] == 15) begin m_st = 2; return; end
        tick = (m_live % TD) == TD - 1;
        m_live++;
        for (int i = 0; i < 6; i++) nd[i] = m_need[i];
        ns = m_st;
        if (tick) begin
            nd[0] += 1;
            if (m_ticks % 2 == 1) begin nd[1] += 1; nd[3] += 1; nd[5] += 1; end
            if (m_ticks % 4 == 3) nd[2] += 1;
`ifdef NEEDS_SICKNESS_EN
            if (m_need[3] >= 12) nd[2] += 1;
`endif
            nd[4] += (m_st == 1) ? -1 : 1;
            m_ticks++;
        end
        if (v) begin
            if (m_st == 0) begin
                case (code)
                    0: nd[0] -= STEP;
                    1: begin nd[1] -= STEP; nd[4] += 1; end
                    2: nd[2] -= STEP;
                    3: nd[3] -= STEP;
                    4: ns = 1;
                    6: nd[5] -= STEP;
                    default: ;
                endcase
            end else if (code == 5) ns = 0;
        end
        if (m_st == 1 && m_need[4] == 0) ns = 0;
        for (int i = 0; i < 6; i++) m_need[i] = clamp(nd[i]);
        m_st = ns;
    endtask

    always @(negedge clk) begin
        logic [26:0] act, exp;
        if (chk_en) begin
            act = {hunger, happiness, health, hygiene, energy, social, sleeping, dead, action_ready};
            exp = exp_vec();
            c_chk++;
            if (act === exp) c_pass++;
            else $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, act, exp);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        l_chk++;
        if (act == exp) l_pass++;
        else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    endtask

    task automatic step(input bit v, input int code);
        action_valid = v;
        action_code  = code[2:0];
        @(posedge clk);
        model_step(v, code);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7);
    endtask

    // asserted just after a falling edge so it lands between active edges
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_needs", {hunger, happiness, health, hygiene, energy, social}, 0);
        check("rst_async_flags", {sleeping, dead, action_ready}, 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        action_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;

        // idle decay to death, then actions ignored while dead
        idle(60);
        check("decay_hunger15", hunger, 15);
        check("decay_not_dead_yet", dead, 0);
        idle(1);
        check("decay_dead", dead, 1);
        check("decay_ready0", action_ready, 0);
        for (int i = 0; i < 8; i++) step(1'b1, 0);
        check("dead_frozen_hunger", hunger, 15);
        check("dead_still", dead, 1);

        // clamping at zero
        do_reset();
        idle(8);
        check("clamp_pre", hunger, 2);
        step(1'b1, 0);
        check("clamp_feed", hunger, 0);
        do_reset();
        idle(15);
        check("clamp_pre_tick", hunger, 3);
        step(1'b1, 0);
        check("clamp_feed_tick", hunger, 0);

        // sleep cycle with auto wake
        do_reset();
        idle(12);
        check("sleep_energy3", energy, 3);
        step(1'b1, 4);
        check("sleep_entered", sleeping, 1);
        step(1'b1, 0);
        check("sleep_feed_ignored", hunger, 3);
        idle(2);
        check("sleep_energy2", energy, 2);
        idle(4);
        check("sleep_energy1", energy, 1);
        idle(4);
        check("sleep_energy0", energy, 0);
        check("sleep_still", sleeping, 1);
        idle(1);
        check("sleep_autowake", sleeping, 0);

        // hygiene >= 12 with health cleared just before a counter=3 tick
        do_reset();
        for (int k = 0; k < 7; k++) begin
            for (int c = 0; c < 16; c++) begin
                if (k % 2 == 0) begin
                    if (c == 1 || c == 2)                    step(1'b1, 0);
                    else if (c == 4)                         step(1'b1, 2);
                    else if (c == 5)                         step(1'b1, 6);
                    else if (k == 6 && (c == 13 || c == 14)) step(1'b1, 2);
                    else                                     step(1'b0, 7);
                end else begin
                    if (c == 0) step(1'b1, 4);
                    else        step(1'b0, 7);
                end
                if (k == 6 && c == 14) check("sick_pre_health", health, 0);
            end
        end
        check("sick_hygiene", hygiene >= 12, 1);
`ifdef NEEDS_SICKNESS_EN
        check("sick_health", health, 2);
`else
        check("sick_health", health, 1);
`endif

        // randomized episodes, some ended by a mid-run reset with an action pending
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 20)      step(1'b1, 0);
                else if (r < 55) step(1'b1, $urandom_range(0, 7));
                else             step(1'b0, $urandom_range(0, 7));
            end
            action_valid = 1'b1;
            action_code  = 3'd0;
        end
        do_reset();
        idle(3);
        check("post_reset_no_tick", hunger, 0);
        idle(1);
        check("post_reset_first_tick", hunger, 1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", c_pass + l_pass, c_chk + l_chk);
        $finish;
    end
endmodule
